// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised pipeline stall/flush/redirect control with memory-wait watchdog.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_stall_i,
  input  logic        branch_flush_i,
  input  logic [31:0] branch_target_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_addr_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
);
  typedef enum logic [1:0] {RUN, DIV_WAIT, MEM_WAIT} state_t;
  state_t state, state_n;
  logic div_pend, div_pend_n;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic abort, mem_stall, run_start, div_stall;
  always_comb begin
    abort = state == MEM_WAIT && wait_cnt == 8'(MEM_TIMEOUT) && !mem_ready_i;
    mem_stall = mem_req_i && !mem_ready_i;
    run_start = state == RUN && div_start_i;
    div_stall = run_start || (div_pend && !div_done_i);
    // a divide issued while memory stalls is re-issued later by the held EXE stage
    div_pend_n = abort ? 1'b0 : (run_start && !mem_stall) ? 1'b1 : div_pend && !div_done_i;
    state_n = abort ? RUN : mem_stall ? MEM_WAIT : div_pend_n ? DIV_WAIT : RUN;
    wait_cnt_n = (!abort && mem_stall && state == MEM_WAIT) ? wait_cnt + 8'd1 : 8'd0;
    {stall_o, flush_o, pc_redirect_o, pc_redirect_addr_o, mem_err_o} =
      rst              ? {5'b00000, 5'b11111, 1'b0, 32'd0, 1'b0} :
      abort            ? {5'b00000, 5'b11110, 1'b1, TRAP_VEC, 1'b1} :
      mem_stall        ? {5'b01111, 5'b10000, 1'b0, 32'd0, 1'b0} :
      div_stall        ? {5'b00111, 5'b01000, 1'b0, 32'd0, 1'b0} :
      branch_flush_i   ? {5'b00000, 5'b00110, 1'b1, branch_target_i, 1'b0} :
      load_use_stall_i ? {5'b00011, 5'b00100, 1'b0, 32'd0, 1'b0} :
                         44'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      div_pend <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_n;
      div_pend <= div_pend_n;
      wait_cnt <= wait_cnt_n;
    end
  end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= 32'd0;
      flush_events_o <= 32'd0;
    end else begin
      if (|stall_o && !(&stall_cycles_o)) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (pc_redirect_o && !(&flush_events_o)) flush_events_o <= flush_events_o + 32'd1;
    end
  end
`else
  assign stall_cycles_o = 32'd0;
  assign flush_events_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of priority, divide/memory waits, watchdog, reset and perf counters.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, lu, bf, ds, dd, mr, mrdy;
  logic [31:0] bt;
  logic [4:0] stall_o, flush_o;
  logic pc_redirect_o, mem_err_o;
  logic [31:0] pc_redirect_addr_o, stall_cycles_o, flush_events_o;
  logic [43:0] outs;
  int total = 0;
  int bad = 0;
  assign outs = {stall_o, flush_o, pc_redirect_o, pc_redirect_addr_o, mem_err_o};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .load_use_stall_i(lu), .branch_flush_i(bf), .branch_target_i(bt),
    .div_start_i(ds), .div_done_i(dd), .mem_req_i(mr), .mem_ready_i(mrdy),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
    .pc_redirect_addr_o(pc_redirect_addr_o), .mem_err_o(mem_err_o),
    .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
  );
  function automatic logic [43:0] o(input logic [4:0] s, input logic [4:0] f, input logic r,
                                    input logic [31:0] a, input logic e);
    return {s, f, r, a, e};
  endfunction
  function automatic logic [31:0] pv(input logic [31:0] v);
    return v & {32{PERF}};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic l, input logic b, input logic [31:0] t, input logic s,
                        input logic d, input logic r, input logic y);
    lu = l; bf = b; bt = t; ds = s; dd = d; mr = r; mrdy = y;
  endtask
  task automatic cyc(input string tag, input logic [43:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic perf(input string tag, input logic [31:0] s, input logic [31:0] f);
    chk({tag, "_stall_cnt"}, stall_cycles_o, pv(s));
    chk({tag, "_flush_cnt"}, flush_events_o, pv(f));
  endtask
  initial begin
    rst = 1'b1;
    set_in(1, 1, 32'h200, 1, 0, 1, 0);
    cyc("rst_outputs", o(5'b00000, 5'b11111, 0, 0, 0));
    perf("after_rst", 0, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("idle", 44'd0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc("load_use", o(5'b00011, 5'b00100, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("load_use_clear", 44'd0);
    set_in(1, 1, 32'h200, 0, 0, 0, 0);
    cyc("branch_over_lu", o(5'b00000, 5'b00110, 1, 32'h200, 0));
    perf("after_branch", 1, 1);
    set_in(0, 0, 0, 1, 0, 0, 0);
    cyc("div_start", o(5'b00111, 5'b01000, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("div_wait", o(5'b00111, 5'b01000, 0, 0, 0));
    set_in(0, 0, 0, 0, 1, 0, 0);
    cyc("div_done", 44'd0);
    set_in(0, 0, 0, 0, 1, 0, 0);
    cyc("done_ignored_in_run", 44'd0);
    set_in(0, 0, 0, 1, 0, 0, 0);
    cyc("div_start2", o(5'b00111, 5'b01000, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("mem_in_div1", o(5'b01111, 5'b10000, 0, 0, 0));
    set_in(0, 0, 0, 0, 1, 1, 0);
    cyc("mem_in_div2_done", o(5'b01111, 5'b10000, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("mem_in_div3", o(5'b01111, 5'b10000, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1, 1);
    cyc("mem_ready_no_div", 44'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("run_after_mem", 44'd0);
    perf("after_div", 9, 1);
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("mem_wait_bnd", o(5'b01111, 5'b10000, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1, 1);
    cyc("ready_beats_abort", 44'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("idle_after_bnd", 44'd0);
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc("mem_wait_pre_rst", o(5'b01111, 5'b10000, 0, 0, 0));
    perf("before_rst", 16, 1);
    rst = 1'b1;
    cyc("rst_mid_wait", o(5'b00000, 5'b11111, 0, 0, 0));
    perf("rst_mid_wait", 0, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 1);
    cyc("post_rst_ready", 44'd0);
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("timeout_wait", o(5'b01111, 5'b10000, 0, 0, 0));
    cyc("abort", o(5'b00000, 5'b11110, 1, 32'h10, 1));
    perf("after_abort", 5, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("after_abort_idle", 44'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
